// File: rtl/uart_rx_if.sv
// Serial-line and result signals of the UART receive path, grouped for uart_receiver.
// The slave modport is the receiver's view; master is the stimulus/consumer side.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 tick_in;
    logic                 rx_in;
    logic [DATA_BITS-1:0] data_out;
    logic                 rx_done;
    logic                 frame_error;
    logic                 rx_busy;

    modport master (
        output tick_in, rx_in,
        input  data_out, rx_done, frame_error, rx_busy
    );

    modport slave (
        input  tick_in, rx_in,
        output data_out, rx_done, frame_error, rx_busy
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver on a 16x oversampled baud tick; one-cycle rx_done / frame_error strobes.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 vote over samples 6,7,8.
module uart_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input logic     system_clk,
    input logic     rst,
    uart_rx_if.slave bus
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [SW-1:0] DECIDE = SW'(OVERSAMPLE / 2);
`else
    localparam logic [SW-1:0] DECIDE = SW'(OVERSAMPLE / 2 - 1);
`endif

    typedef enum logic [1:0] {IDLE, START, READ, STOP} state_e;

    state_e               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [SW-1:0]        s_cnt_q, s_cnt_d;
    logic [BW-1:0]        b_cnt_q, b_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic                 bit_val;

`ifdef UART_RX_MAJORITY_EN
    logic samp6_q, samp7_q;

    // The two earlier samples are held so the third (live rx_s) completes the vote.
    always_ff @(posedge system_clk) begin
        if (rst) begin
            samp6_q <= 1'b1;
            samp7_q <= 1'b1;
        end else if (bus.tick_in) begin
            if (s_cnt_q == DECIDE - SW'(2)) samp6_q <= rx_s_q;
            if (s_cnt_q == DECIDE - SW'(1)) samp7_q <= rx_s_q;
        end
    end

    assign bit_val = (samp6_q & samp7_q) | (samp6_q & rx_s_q) | (samp7_q & rx_s_q);
`else
    assign bit_val = rx_s_q;
`endif

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        b_cnt_d = b_cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                s_cnt_d = '0;
                b_cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: if (bus.tick_in) begin
                s_cnt_d = s_cnt_q + SW'(1);
                if (s_cnt_q == DECIDE && bit_val) begin
                    state_d = IDLE;
                end else if (s_cnt_q == S_LAST) begin
                    state_d = READ;
                    s_cnt_d = '0;
                end
            end
            READ: if (bus.tick_in) begin
                s_cnt_d = s_cnt_q + SW'(1);
                if (s_cnt_q == DECIDE) shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                if (s_cnt_q == S_LAST) begin
                    s_cnt_d = '0;
                    if (b_cnt_q == B_LAST) state_d = STOP;
                    else                   b_cnt_d = b_cnt_q + BW'(1);
                end
            end
            STOP: if (bus.tick_in) begin
                s_cnt_d = s_cnt_q + SW'(1);
                // Leave at mid stop bit so a back-to-back start edge is not missed.
                if (s_cnt_q == DECIDE) begin
                    data_d  = shift_q;
                    done_d  = bit_val;
                    ferr_d  = ~bit_val;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge system_clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            s_cnt_q   <= '0;
            b_cnt_q   <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= bus.rx_in;
            rx_s_q    <= rx_meta_q;
            s_cnt_q   <= s_cnt_d;
            b_cnt_q   <= b_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    assign bus.data_out    = data_q;
    assign bus.rx_done     = done_q;
    assign bus.frame_error = ferr_q;
    assign bus.rx_busy     = (state_q != IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// Randomized self-checking bench for uart_receiver: frames are queued as expected
// results from their bit content and a per-cycle monitor compares outputs against them.
module tb_uart_receiver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;
    int   done_cnt = 0;
    int   ferr_cnt = 0;

    typedef struct {
        bit       err;
        bit [7:0] d;
    } ev_t;
    ev_t      exp_q[$];
    bit [7:0] model_data;
    bit       prev_pulse;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .system_clk(clk),
        .rst       (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Monitor: every cycle outside reset, data_out must equal the last reported byte,
    // and every strobe must match the oldest outstanding expected frame.
    always @(negedge clk) begin
        if (rst) begin
            model_data = 8'h00;
            prev_pulse = 1'b0;
        end else begin
            chk("done_and_ferr_together", {31'd0, bus.rx_done & bus.frame_error}, 32'd0);
            if (bus.rx_done || bus.frame_error) begin
                chk("pulse_width", {31'd0, prev_pulse}, 32'd0);
                if (bus.rx_done) done_cnt++;
                if (bus.frame_error) ferr_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 32'd1, 32'd0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("pulse_kind", {31'd0, bus.frame_error}, {31'd0, e.err});
                    model_data = e.d;
                end
            end
            prev_pulse = bus.rx_done | bus.frame_error;
            chk("data_out", {24'd0, bus.data_out}, {24'd0, model_data});
        end
    end

    // One baud tick period: line value held 4 clocks, tick on the last clock.
    task automatic step(input logic v);
        bus.rx_in   = v;
        bus.tick_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.tick_in = 1'b1;
        @(posedge clk);
        #1 bus.tick_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    // Sends one frame; glitch_bit >= 0 pulls that (1) bit low for the single tick at
    // mid-bit. A bad stop bit is low only in its first half so the line recovers cleanly.
    task automatic send_frame(input bit [7:0] d, input bit stop_ok, input int glitch_bit);
        ev_t e;
        e.err = ~stop_ok;
        e.d   = d;
`ifndef UART_RX_MAJORITY_EN
        if (glitch_bit >= 0) e.d[glitch_bit] = 1'b0;
`endif
        exp_q.push_back(e);
        for (int o = 0; o < 16; o++) step(1'b0);
        for (int i = 0; i < 8; i++)
            for (int o = 0; o < 16; o++)
                step(d[i] && !(i == glitch_bit && o == 7));
        chk("busy_in_frame", {31'd0, bus.rx_busy}, 32'd1);
        for (int o = 0; o < 16; o++) step(stop_ok || o >= 8);
    endtask

    initial begin
        int d0, f0;
        bus.rx_in   = 1'b1;
        bus.tick_in = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_out", {24'd0, bus.data_out}, 32'h00);
        chk("rst_rx_done", {31'd0, bus.rx_done}, 32'd0);
        chk("rst_frame_error", {31'd0, bus.frame_error}, 32'd0);
        chk("rst_rx_busy", {31'd0, bus.rx_busy}, 32'd0);
        rst = 1'b0;
        idle(4);

        // Good frame
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1, -1);
        idle(4);
        chk("a5_data", {24'd0, bus.data_out}, 32'hA5);
        chk("a5_done_count", done_cnt - d0, 32'd1);
        chk("a5_ferr_count", ferr_cnt - f0, 32'd0);

        // Framing error
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, -1);
        idle(20);
        chk("3c_data", {24'd0, bus.data_out}, 32'h3C);
        chk("3c_ferr_count", ferr_cnt - f0, 32'd1);
        chk("3c_done_count", done_cnt - d0, 32'd0);

        // False start: short low pulse is rejected mid start bit
        d0 = done_cnt; f0 = ferr_cnt;
        repeat (3) step(1'b0);
        idle(2);
        chk("false_start_busy", {31'd0, bus.rx_busy}, 32'd1);
        idle(11);
        chk("false_start_idle", {31'd0, bus.rx_busy}, 32'd0);
        chk("false_start_pulses", (done_cnt - d0) + (ferr_cnt - f0), 32'd0);

        // Back-to-back frames with no idle gap
        d0 = done_cnt;
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        idle(4);
        chk("b2b_done_count", done_cnt - d0, 32'd2);
        chk("b2b_last_data", {24'd0, bus.data_out}, 32'hFF);

        // Reset in the middle of a byte, then a clean frame
        d0 = done_cnt; f0 = ferr_cnt;
        for (int o = 0; o < 16; o++) step(1'b0);
        for (int i = 0; i < 3; i++)
            for (int o = 0; o < 16; o++) step(i[0]);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_data", {24'd0, bus.data_out}, 32'h00);
        chk("midrst_busy", {31'd0, bus.rx_busy}, 32'd0);
        rst = 1'b0;
        idle(4);
        send_frame(8'h81, 1'b1, -1);
        idle(4);
        chk("midrst_81_data", {24'd0, bus.data_out}, 32'h81);
        chk("midrst_done_count", done_cnt - d0, 32'd1);
        chk("midrst_ferr_count", ferr_cnt - f0, 32'd0);

        // One-tick glitch at mid-bit of bit 3
        send_frame(8'hFF, 1'b1, 3);
        idle(4);
`ifdef UART_RX_MAJORITY_EN
        chk("glitch_data", {24'd0, bus.data_out}, 32'hFF);
`else
        chk("glitch_data", {24'd0, bus.data_out}, 32'hF7);
`endif

        // Random frames, random stop validity and gaps
        for (int n = 0; n < 24; n++) begin
            bit [7:0] d;
            bit       ok;
            int       gap;
            d   = 8'($urandom);
            ok  = ($urandom_range(0, 3) != 0);
            gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 20));
            send_frame(d, ok, -1);
            idle(gap);
        end
        idle(20);
        chk("all_frames_reported", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
